uart_receiver: RTL and testbench

- Receive stage of the UART path, directly downstream of the baud-rate generator.
- Samples the serial rx line on each 16x-oversampling tick and deserialises one asynchronous frame: start bit, DBITS data bits LSB-first, optional parity bit, stop bit(s).
- Presents the received word to the RX FIFO and interface logic with a one-cycle done strobe and error flags.
- Everything is clocked by the system clock; baud timing comes only from the tick input.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_2ff.sv | 26 ++
 rtl/uart_receiver.sv | 181 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OS_TICKS    = 16;
  localparam int START_MID   = 7;
  localparam int DBITS_DEF   = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous serial-side inputs.
// Both flops reset to 1 so that an idle line reads as idle during reset.
module uart_sync_2ff (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle any metastability.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: deserialises one frame per start edge using the
// 16x oversampling tick. Optional parity checking is built in when
// UART_RX_PARITY_CHECK_EN is defined; otherwise parity_err is tied 0.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | line idle, waiting for rx_s to fall
// ST_START  | counting to mid start bit; line high there = glitch
// ST_DATA   | sampling DBITS data bits, LSB first, every 16 ticks
// ST_PARITY | sampling the parity bit (parity build only)
// ST_STOP   | counting out the stop time, then publishing results
import uart_pkg::*;

module uart_receiver #(
  parameter int DBITS   = DBITS_DEF,
  parameter int SB_TICK = SB_TICK_DEF
`ifdef UART_RX_PARITY_CHECK_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic             rx_done_tick,
  output logic [DBITS-1:0] dout,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [NW-1:0] N_LAST     = NW'(DBITS - 1);
  localparam logic [4:0]    S_MID      = 5'(START_MID);
  localparam logic [4:0]    S_BIT_END  = 5'(OS_TICKS - 1);
  localparam logic [4:0]    S_STOP_END = 5'(SB_TICK - 1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [4:0]       s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [DBITS-1:0] b_q, b_d;
  logic [DBITS-1:0] dout_q, dout_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_CHECK_EN
  logic             p_q, p_d;
  logic             perr_q, perr_d;
`endif

  uart_sync_2ff u_sync_rx (
    .clk_sys (clk_100MHz),
    .rst_b   (reset),
    .d       (rx),
    .q       (rx_s)
  );

  // Next-state and datapath decode; counters only move on sample ticks.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_CHECK_EN
    p_d     = p_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = 5'd0;
        end
      end
      ST_START: begin
        if (sample_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = 5'd0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          if (s_q == S_BIT_END) begin
            s_d = 5'd0;
            b_d = {rx_s, b_q[DBITS-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_CHECK_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_CHECK_EN
      ST_PARITY: begin
        if (sample_tick) begin
          if (s_q == S_BIT_END) begin
            p_d     = rx_s;
            s_d     = 5'd0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (sample_tick) begin
          if (s_q == S_STOP_END) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_CHECK_EN
            perr_d  = ((^b_q) ^ p_q) != PARITY_ODD;
`endif
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset aborts any frame.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= 5'd0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      p_q     <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_CHECK_EN
      p_q     <= p_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_CHECK_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver. Expected words are queued as frames
// are driven and compared when rx_done_tick fires. Defining
// UART_RX_PARITY_CHECK_EN adds a parity bit to every frame and parity cases.
module tb_uart_receiver;

  localparam int TICK_DIV = 16;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam int FRAME_TICKS = 8 + 16 * 8 + 16 + 16;
`else
  localparam int FRAME_TICKS = 8 + 16 * 8 + 16;
`endif

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         t0;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       sample_tick;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       parity_err;

  int   total = 0;
  int   bad = 0;
  int   tick_cnt = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  exp_t sb[$];

  uart_receiver dut (
    .clk_100MHz   (clk),
    .reset        (rst_n),
    .rx           (rx),
    .sample_tick  (sample_tick),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every TICK_DIV clocks, driven on the falling edge.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      sample_tick = 1'b1;
      tick_cnt++;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int tgt;
    tgt = tick_cnt + n;
    while (tick_cnt < tgt) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit par);
    exp_t e;
    e.d  = data;
    e.fe = !stop_ok;
`ifdef UART_RX_PARITY_CHECK_EN
    e.pe = ((^data) ^ par) != 1'b0;
`else
    e.pe = 1'b0;
`endif
    e.t0 = tick_cnt;
    sb.push_back(e);
    exp_done++;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_CHECK_EN
    rx = par;
    wait_ticks(16);
`endif
    if (stop_ok) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      rx = 1'b0;
      wait_ticks(12);
      rx = 1'b1;
      wait_ticks(4);
    end
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk_eq({"drain_", tag}, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk_eq("done_width", 32'(rx_done_tick), 32'd0);
      if (rx_done_tick && !prev_done) begin
        if (sb.size() == 0) begin
          chk_eq("done_unexpected", 32'(rx_done_tick), 32'd0);
        end else begin
          e = sb.pop_front();
          done_cnt++;
          chk_eq("dout", 32'(dout), 32'(e.d));
          chk_eq("frame_err", 32'(frame_err), 32'(e.fe));
          chk_eq("parity_err", 32'(parity_err), 32'(e.pe));
          chk_eq("done_latency", 32'(tick_cnt - e.t0), 32'(FRAME_TICKS));
        end
      end
      prev_done = rx_done_tick;
    end
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk_eq("rst_dout", 32'(dout), 32'd0);
    chk_eq("rst_done", 32'(rx_done_tick), 32'd0);
    chk_eq("rst_ferr", 32'(frame_err), 32'd0);
    chk_eq("rst_perr", 32'(parity_err), 32'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    // Short low pulse: rejected at mid start bit.
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    chk_eq("glitch_dout", 32'(dout), 32'd0);
    chk_eq("glitch_ferr", 32'(frame_err), 32'd0);
    chk_eq("glitch_done_cnt", 32'(done_cnt), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0);
    wait_drain("a5");
    wait_ticks(20);

    send_frame(8'h3C, 1'b0, 1'b0);
    wait_drain("3c_bad_stop");
    wait_ticks(20);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_drain("3c_good");
    wait_ticks(20);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_drain("b2b");
    wait_ticks(20);

    // Abort 0x55 after three data bits with a reset pulse.
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_eq("abort_dout", 32'(dout), 32'd0);
    chk_eq("abort_done", 32'(rx_done_tick), 32'd0);
    rst_n = 1'b1;
    wait_ticks(20);
    chk_eq("abort_no_done", 32'(done_cnt), 32'(exp_done));
    send_frame(8'h81, 1'b1, 1'b0);
    wait_drain("81");
    wait_ticks(20);

`ifdef UART_RX_PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain("par_ok");
    wait_ticks(20);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_drain("par_bad");
    wait_ticks(20);
`endif

    chk_eq("done_count", 32'(done_cnt), 32'(exp_done));
    chk_eq("sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
